trap_ctrl: RTL and testbench

- Trap sequencer in the writeback stage, directly upstream of the machine-mode CSR register file.
- Detects exceptions, external interrupts and mret from the retiring instruction.
- Serialises the required CSR updates through the CSR file's single write port (mepc, mcause, mtval, mstatus).
- Issues a one-cycle PC redirect plus pipeline flush, and stalls the pipeline for the whole sequence.

---
 rtl/trap_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer for the writeback stage.
// It picks one event per retiring instruction: an external interrupt, a
// synchronous exception or mret. It then serialises the machine-mode CSR
// updates through the CSR file's single write port, stalls the pipeline for
// the whole sequence, and finishes with a one-cycle redirect plus flush.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   valid_wb, pc_wb,      retiring instruction: valid flag, PC, instruction
//   inst_wb, addr_wb      word and load/store effective address
//   exc_*, mret, ext_int  event requests from writeback / interrupt line
//   mstatus_in, mtvec_in, current CSR values from the CSR file
//   mepc_in
//   csr_w, csr_waddr,     CSR write port (registered)
//   csr_wdata,
//   csr_wsc_mode
//   expt_int              trap-entry pulse (registered)
//   stall                 pipeline hold (combinational while in IDLE)
//   flush, redirect_valid one-cycle flush and PC load (registered)
//   redirect_pc           redirect target (registered)
module trap_ctrl #(
  parameter bit          MTVEC_VECTORED_EN = 1'b1,
  parameter int unsigned EXT_INT_CODE      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_wb,
  input  logic [31:0] pc_wb,
  input  logic [31:0] inst_wb,
  input  logic [31:0] addr_wb,
  input  logic        exc_illegal,
  input  logic        exc_ecall,
  input  logic        exc_l_fault,
  input  logic        exc_s_fault,
  input  logic        mret,
  input  logic        ext_int,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_w,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc_mode,
  output logic        expt_int,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;

  localparam logic [AW-1:0] ADDR_MSTATUS = 12'h300;
  localparam logic [AW-1:0] ADDR_MEPC    = 12'h341;
  localparam logic [AW-1:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [AW-1:0] ADDR_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] CAUSE_EXT_INT = {1'b1, 31'(EXT_INT_CODE)};

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, REDIRECT
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic              csr_w_q, csr_w_d;
  logic [AW-1:0]     csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              expt_int_q, expt_int_d;
  logic              flush_q, flush_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic              int_take_c, exc_any_c, trap_take_c, mret_take_c;
  logic [XLEN-1:0]   ev_cause_c, ev_tval_c;
  logic [XLEN-1:0]   trap_mstatus_c, mret_mstatus_c;
  logic [XLEN-1:0]   mtvec_base_c, trap_target_c;
  logic              vectored_c;

  // Event detection and fixed-priority cause/tval selection
  always_comb begin
    int_take_c  = ext_int & mstatus_in[3];
    exc_any_c   = exc_illegal | exc_ecall | exc_l_fault | exc_s_fault;
    trap_take_c = valid_wb & (int_take_c | exc_any_c);
    mret_take_c = valid_wb & mret & ~trap_take_c;
    ev_cause_c  = '0;
    ev_tval_c   = '0;
    if (int_take_c) begin
      ev_cause_c = CAUSE_EXT_INT;
    end else if (exc_illegal) begin
      ev_cause_c = 32'd2;
      ev_tval_c  = inst_wb;
    end else if (exc_ecall) begin
      ev_cause_c = 32'd11;
    end else if (exc_l_fault) begin
      ev_cause_c = 32'd5;
      ev_tval_c  = addr_wb;
    end else if (exc_s_fault) begin
      ev_cause_c = 32'd7;
      ev_tval_c  = addr_wb;
    end
  end

  // mstatus images for trap entry and mret; MPP always lands at machine mode
  always_comb begin
    trap_mstatus_c        = mstatus_in;
    trap_mstatus_c[7]     = mstatus_in[3];
    trap_mstatus_c[3]     = 1'b0;
    trap_mstatus_c[12:11] = 2'b11;
    mret_mstatus_c        = mstatus_in;
    mret_mstatus_c[3]     = mstatus_in[7];
    mret_mstatus_c[7]     = 1'b1;
    mret_mstatus_c[12:11] = 2'b11;
  end

  // Vectored mode applies to interrupts only; exceptions always use the base
  always_comb begin
    mtvec_base_c  = {mtvec_in[31:2], 2'b00};
    vectored_c    = MTVEC_VECTORED_EN && (mtvec_in[1:0] == 2'b01) && cause_q[31];
    trap_target_c = vectored_c ? (mtvec_base_c + {cause_q[29:0], 2'b00}) : mtvec_base_c;
  end

  // Next state plus next registered outputs, which are decoded from state_d
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    tval_d           = tval_q;
    csr_w_d          = 1'b0;
    csr_waddr_d      = '0;
    csr_wdata_d      = '0;
    expt_int_d       = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;

    case (state_q)
      IDLE: begin
        if (trap_take_c) begin
          state_d = W_MEPC;
          cause_d = ev_cause_c;
          epc_d   = pc_wb;
          tval_d  = ev_tval_c;
        end else if (mret_take_c) begin
          state_d = M_MSTATUS;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MTVAL;
      W_MTVAL:   state_d = W_MSTATUS;
      W_MSTATUS: begin
        state_d       = REDIRECT;
        redirect_pc_d = trap_target_c;
      end
      M_MSTATUS: begin
        state_d       = REDIRECT;
        redirect_pc_d = mepc_in;
      end
      REDIRECT:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    case (state_d)
      W_MEPC: begin
        csr_w_d     = 1'b1;
        csr_waddr_d = ADDR_MEPC;
        csr_wdata_d = epc_d;
        expt_int_d  = 1'b1;
      end
      W_MCAUSE: begin
        csr_w_d     = 1'b1;
        csr_waddr_d = ADDR_MCAUSE;
        csr_wdata_d = cause_d;
      end
      W_MTVAL: begin
        csr_w_d     = 1'b1;
        csr_waddr_d = ADDR_MTVAL;
        csr_wdata_d = tval_d;
      end
      W_MSTATUS: begin
        csr_w_d     = 1'b1;
        csr_waddr_d = ADDR_MSTATUS;
        csr_wdata_d = trap_mstatus_c;
      end
      M_MSTATUS: begin
        csr_w_d     = 1'b1;
        csr_waddr_d = ADDR_MSTATUS;
        csr_wdata_d = mret_mstatus_c;
      end
      REDIRECT: begin
        redirect_valid_d = 1'b1;
        flush_d          = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched trap info and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cause_q          <= '0;
      epc_q            <= '0;
      tval_q           <= '0;
      csr_w_q          <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      expt_int_q       <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      tval_q           <= tval_d;
      csr_w_q          <= csr_w_d;
      csr_waddr_q      <= csr_waddr_d;
      csr_wdata_q      <= csr_wdata_d;
      expt_int_q       <= expt_int_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Stall has to cover the detection cycle itself, so it cannot be registered
  always_comb begin
    if (state_q == IDLE) stall = rst & (trap_take_c | mret_take_c);
    else                 stall = rst & (state_q != REDIRECT);
  end

  assign csr_w          = csr_w_q;
  assign csr_waddr      = csr_waddr_q;
  assign csr_wdata      = csr_wdata_q;
  assign csr_wsc_mode   = 2'b00;
  assign expt_int       = expt_int_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: each scenario pushes the CSR writes and redirect it
// expects into scoreboard queues; a negedge monitor pops and compares them
// as the DUT produces them, and the scenario tasks check stall length,
// event counts and queue drain inline.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_wb;
  logic [31:0] pc_wb, inst_wb, addr_wb;
  logic        exc_illegal, exc_ecall, exc_l_fault, exc_s_fault;
  logic        mret, ext_int;
  logic [31:0] mstatus_in, mtvec_in, mepc_in;
  logic        csr_w;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_wsc_mode;
  logic        expt_int, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int writes_seen = 0;
  int redirects_seen = 0;

  logic [43:0] wq[$];   // {addr, data}
  logic [31:0] rq[$];   // redirect targets

  trap_ctrl #(.MTVEC_VECTORED_EN(1'b1), .EXT_INT_CODE(11)) dut (
    .clk(clk), .rst(rst), .valid_wb(valid_wb), .pc_wb(pc_wb),
    .inst_wb(inst_wb), .addr_wb(addr_wb), .exc_illegal(exc_illegal),
    .exc_ecall(exc_ecall), .exc_l_fault(exc_l_fault), .exc_s_fault(exc_s_fault),
    .mret(mret), .ext_int(ext_int), .mstatus_in(mstatus_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .csr_w(csr_w),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wsc_mode(csr_wsc_mode),
    .expt_int(expt_int), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops expected writes/redirects as the DUT emits them
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [43:0] w;
      n_checks++;
      if (csr_w === 1'b1) begin
        writes_seen++;
        if (wq.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", csr_waddr, csr_wdata);
        end else begin
          w = wq.pop_front();
          if ({csr_waddr, csr_wdata} !== w || expt_int !== (w[43:32] == 12'h341))
            $display("FAIL csr_write: got addr=%h data=%h expt=%b, required addr=%h data=%h",
                     csr_waddr, csr_wdata, expt_int, w[43:32], w[31:0]);
          else n_pass++;
        end
      end else begin
        if (csr_waddr !== 12'h0 || csr_wdata !== 32'h0 || expt_int !== 1'b0 || csr_wsc_mode !== 2'b00)
          $display("FAIL idle_port: got addr=%h data=%h expt=%b mode=%b, required all 0",
                   csr_waddr, csr_wdata, expt_int, csr_wsc_mode);
        else n_pass++;
      end
      n_checks++;
      if (redirect_valid === 1'b1) begin
        redirects_seen++;
        if (rq.size() == 0) begin
          $display("FAIL unexpected_redirect: got pc=%h, required none", redirect_pc);
        end else begin
          logic [31:0] r;
          r = rq.pop_front();
          if (redirect_pc !== r || flush !== 1'b1 || stall !== 1'b0 || csr_w !== 1'b0)
            $display("FAIL redirect: got pc=%h flush=%b stall=%b, required pc=%h flush=1 stall=0",
                     redirect_pc, flush, stall, r);
          else n_pass++;
        end
      end else begin
        if (flush !== 1'b0)
          $display("FAIL flush_alone: got flush=%b, required 0", flush);
        else n_pass++;
      end
    end
  end

  task automatic clear_events();
    valid_wb = 0; exc_illegal = 0; exc_ecall = 0; exc_l_fault = 0;
    exc_s_fault = 0; mret = 0; ext_int = 0;
  endtask

  // Runs n cycles counting stalled ones (no comparisons here)
  task automatic drain(input int n, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 0; clear_events();
    pc_wb = 0; inst_wb = 0; addr_wb = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({csr_w, csr_waddr, csr_wdata, csr_wsc_mode, expt_int, stall, flush, redirect_valid, redirect_pc} !== '0)
      $display("FAIL reset_outputs: got w=%b a=%h d=%h st=%b rv=%b pc=%h, required all 0",
               csr_w, csr_waddr, csr_wdata, stall, redirect_valid, redirect_pc);
    else n_pass++;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int s0, st, w0, r0;
    w0 = writes_seen; r0 = redirects_seen;
    @(negedge clk);
    valid_wb = 1; exc_illegal = 1; pc_wb = 32'h100; inst_wb = 32'hFFFF_FFFF;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    wq.push_back({12'h341, 32'h100}); wq.push_back({12'h342, 32'd2});
    wq.push_back({12'h343, 32'hFFFF_FFFF}); wq.push_back({12'h300, 32'h1880});
    rq.push_back(32'h200);
    #1 s0 = int'(stall);
    @(negedge clk); clear_events();
    drain(10, st);
    n_checks++;
    if (s0 + st != 5) $display("FAIL illegal_stall: got %0d cycles, required 5", s0 + st);
    else n_pass++;
    n_checks++;
    if (writes_seen - w0 != 4 || redirects_seen - r0 != 1 || wq.size() != 0 || rq.size() != 0)
      $display("FAIL illegal_count: got writes=%0d redirects=%0d, required 4 and 1",
               writes_seen - w0, redirects_seen - r0);
    else n_pass++;
  endtask

  task automatic test_vectored_int();
    int st, w0;
    w0 = writes_seen;
    @(negedge clk);
    valid_wb = 1; ext_int = 1; exc_ecall = 1; pc_wb = 32'h300;
    mstatus_in = 32'h8; mtvec_in = 32'h201;
    wq.push_back({12'h341, 32'h300}); wq.push_back({12'h342, 32'h8000_000B});
    wq.push_back({12'h343, 32'h0}); wq.push_back({12'h300, 32'h1880});
    rq.push_back(32'h22C);
    @(negedge clk); clear_events();
    drain(10, st);
    n_checks++;
    if (st != 4 || writes_seen - w0 != 4 || wq.size() != 0 || rq.size() != 0)
      $display("FAIL vectored_int: got stall=%0d writes=%0d left=%0d, required 4, 4, 0",
               st, writes_seen - w0, wq.size() + rq.size());
    else n_pass++;
  endtask

  task automatic test_int_masked();
    int s0, st, w0, r0;
    w0 = writes_seen; r0 = redirects_seen;
    @(negedge clk);
    valid_wb = 1; ext_int = 1; mstatus_in = 32'h0; mtvec_in = 32'h200;
    #1 s0 = int'(stall);
    drain(8, st);
    clear_events();
    n_checks++;
    if (s0 + st != 0 || writes_seen != w0 || redirects_seen != r0)
      $display("FAIL int_masked: got stall=%0d writes=%0d redirects=%0d, required 0",
               s0 + st, writes_seen - w0, redirects_seen - r0);
    else n_pass++;
  endtask

  task automatic test_mret();
    int s0, st, w0;
    w0 = writes_seen;
    @(negedge clk);
    valid_wb = 1; mret = 1; mstatus_in = 32'h80; mepc_in = 32'h104; mtvec_in = 32'h200;
    wq.push_back({12'h300, 32'h1888});
    rq.push_back(32'h104);
    #1 s0 = int'(stall);
    @(negedge clk); clear_events();
    drain(8, st);
    n_checks++;
    if (s0 + st != 2 || writes_seen - w0 != 1 || wq.size() != 0 || rq.size() != 0)
      $display("FAIL mret: got stall=%0d writes=%0d, required 2 and 1", s0 + st, writes_seen - w0);
    else n_pass++;
  endtask

  task automatic test_priority_valid();
    int s0, st, w0;
    w0 = writes_seen;
    @(negedge clk);
    valid_wb = 1; exc_l_fault = 1; exc_s_fault = 1; mret = 1; addr_wb = 32'h55;
    pc_wb = 32'h400; mstatus_in = 32'h0; mtvec_in = 32'h200;
    wq.push_back({12'h341, 32'h400}); wq.push_back({12'h342, 32'd5});
    wq.push_back({12'h343, 32'h55}); wq.push_back({12'h300, 32'h1800});
    rq.push_back(32'h200);
    @(negedge clk); clear_events();
    drain(10, st);
    n_checks++;
    if (st != 4 || writes_seen - w0 != 4 || wq.size() != 0 || rq.size() != 0)
      $display("FAIL priority: got stall=%0d writes=%0d, required 4 and 4", st, writes_seen - w0);
    else n_pass++;
    // Same events without valid_wb must be ignored
    w0 = writes_seen;
    valid_wb = 0; exc_l_fault = 1; exc_s_fault = 1; exc_illegal = 1;
    #1 s0 = int'(stall);
    drain(6, st);
    clear_events();
    n_checks++;
    if (s0 + st != 0 || writes_seen != w0)
      $display("FAIL not_valid: got stall=%0d writes=%0d, required 0", s0 + st, writes_seen - w0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int st, w0;
    @(negedge clk);
    valid_wb = 1; exc_ecall = 1; pc_wb = 32'h500; mstatus_in = 32'h8; mtvec_in = 32'h200;
    wq.push_back({12'h341, 32'h500});
    @(negedge clk); clear_events();      // W_MEPC, write popped by monitor
    @(posedge clk);                      // now W_MCAUSE
    #2 rst = 0;
    #1;
    n_checks++;
    if ({csr_w, csr_waddr, csr_wdata, expt_int, stall, flush, redirect_valid, redirect_pc} !== '0)
      $display("FAIL reset_async: got w=%b a=%h d=%h st=%b, required all 0",
               csr_w, csr_waddr, csr_wdata, stall);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1;
    drain(3, st);
    n_checks++;
    if (st != 0 || wq.size() != 0 || csr_w !== 1'b0)
      $display("FAIL reset_idle: got stall=%0d pending=%0d w=%b, required 0", st, wq.size(), csr_w);
    else n_pass++;
    w0 = writes_seen;
    valid_wb = 1; exc_ecall = 1; pc_wb = 32'h600;
    wq.push_back({12'h341, 32'h600}); wq.push_back({12'h342, 32'd11});
    wq.push_back({12'h343, 32'h0}); wq.push_back({12'h300, 32'h1880});
    rq.push_back(32'h200);
    @(negedge clk); clear_events();
    drain(10, st);
    n_checks++;
    if (st != 4 || writes_seen - w0 != 4 || wq.size() != 0 || rq.size() != 0)
      $display("FAIL ecall_after_reset: got stall=%0d writes=%0d, required 4 and 4", st, writes_seen - w0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_vectored_int();
    test_int_masked();
    test_mret();
    test_priority_valid();
    test_reset_mid();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
